// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   fetch_state_t    - sequencer state (FETCH, HOLD, FAULT)
//   BYTES_PER_INST   - bytes read per instruction word
//   DEFAULT_RESET_PC - PC used when the top is not overridden
//   pc_legal()       - alignment and range check for any PC load
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int unsigned BYTES_PER_INST   = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // A PC is usable when it is word aligned and the whole word pc..pc+3 lies
  // inside the memory. The sum is formed in 33 bits so that a PC close to
  // 2^32 cannot wrap into a small, apparently legal, address.
  function automatic logic pc_legal(input logic [31:0] pc, input int unsigned depth);
    logic [32:0] last_byte;
    last_byte = {1'b0, pc} + 33'd3;
    return (pc[1:0] == 2'b00) && (last_byte < 33'(depth));
  endfunction

endpackage

// File: rtl/fetch_byte_assembler.sv
// Four-lane byte register that builds a little-endian 32-bit instruction word.
// Latency: a written byte appears on word_o one edge after we_i.
// Backpressure: none; the caller decides when to write or clear.
//
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   we_i          - write byte_i into lane lane_i
//   lane_i        - lane select (byte k lands in bits [8k+7:8k])
//   byte_i        - byte to store
//   clr_i         - zero all lanes (takes priority over we_i)
//   word_o        - assembled word
module fetch_byte_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  input  logic        clr_i,
  output logic [31:0] word_o
);

  logic [31:0] word_q;
  logic [31:0] word_d;

  always_comb begin
    word_d = word_q;
    if (clr_i) begin
      word_d = 32'h0;
    end else if (we_i) begin
      word_d[{3'(lane_i), 3'b000} +: 8] = byte_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= 32'h0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: reads four bytes per instruction and presents the word to decode.
// Latency: 4 edges per word from a PC load, 1 extra edge for a redirect to take effect.
// Backpressure: holds inst/inst_pc/inst_valid stable while inst_ready is low; no reads meanwhile.
//
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   mem_addr, mem_rd, mem_rdata - byte read port (rdata is combinational on mem_addr)
//   inst, inst_pc, inst_valid   - assembled instruction, its address, valid
//   inst_ready                  - decode accepts inst
//   redirect_valid, redirect_pc - PC redirect from execute
//   fault                       - fetch stopped on misaligned/out-of-range PC
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      mem_addr,
  output logic             mem_rd,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             fault
);

  localparam logic RESET_LEGAL = pc_legal(RESET_PC, DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   bc_q, bc_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;
  // A redirect is taken in two steps: the sampling edge drops inst_valid and
  // discards the partial word, the following edge loads the target PC. While
  // redir_q is set nothing is read and nothing is handed to decode.
  logic         redir_q, redir_d;
  logic [31:0]  redir_pc_q, redir_pc_d;

  logic         asm_we;
  logic         asm_clr;
  logic [31:0]  pc_inc;

  assign pc_inc = pc_q + 32'(BYTES_PER_INST);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    bc_d       = bc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    redir_d    = 1'b0;
    redir_pc_d = redir_pc_q;
    asm_we     = 1'b0;
    asm_clr    = 1'b0;

    if (redirect_valid) begin
      // Redirect wins over everything, including a handshake in the same
      // cycle: that instruction is still consumed (valid drops now), but the
      // +4 increment never happens.
      redir_d    = 1'b1;
      redir_pc_d = redirect_pc;
      valid_d    = 1'b0;
      bc_d       = 2'd0;
      asm_clr    = 1'b1;
    end else if (redir_q) begin
      pc_d = redir_pc_q;
      bc_d = 2'd0;
      if (pc_legal(redir_pc_q, DEPTH)) begin
        state_d = FETCH;
        fault_d = 1'b0;
      end else begin
        state_d = FAULT;
        fault_d = 1'b1;
      end
    end else begin
      case (state_q)
        FETCH: begin
          asm_we = 1'b1;
          bc_d   = bc_q + 2'd1;
          if (bc_q == 2'd3) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
        HOLD: begin
          // Only a real handshake advances; a stray ready with valid low
          // (not reachable in HOLD today) is ignored.
          if (valid_q && inst_ready) begin
            pc_d    = pc_inc;
            valid_d = 1'b0;
            bc_d    = 2'd0;
            if (pc_legal(pc_inc, DEPTH)) begin
              state_d = FETCH;
            end else begin
              state_d = FAULT;
              fault_d = 1'b1;
            end
          end
        end
        FAULT: begin
          // Parked until a redirect to a legal target.
        end
        default: begin
          state_d = FAULT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RESET_LEGAL ? FETCH : FAULT;
      pc_q       <= RESET_PC;
      bc_q       <= 2'd0;
      valid_q    <= 1'b0;
      fault_q    <= !RESET_LEGAL;
      redir_q    <= 1'b0;
      redir_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      bc_q       <= bc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  fetch_byte_assembler u_asm (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   (asm_we),
    .lane_i (bc_q),
    .byte_i (mem_rdata[7:0]),
    .clr_i  (asm_clr),
    .word_o (inst)
  );

  // Read port is driven straight from state so the byte for lane bc arrives
  // in the same cycle it is captured.
  assign mem_rd     = (state_q == FETCH) && !redir_q;
  assign mem_addr   = mem_rd ? (pc_q + {30'd0, bc_q}) : pc_q;
  assign inst_pc    = pc_q;
  assign inst_valid = valid_q;
  assign fault      = fault_q;

endmodule
